// File: rtl/conv3x3_stream_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine: mode codes,
// kernel coefficient tables and accumulator sizing.
package conv_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_SOBX = 2'b01;
  localparam logic [1:0] MODE_SOBY = 2'b10;
  localparam logic [1:0] MODE_LAP  = 2'b11;

  // [row][col] of 4-bit two's-complement coefficients, row 0 is the top row
  typedef logic [0:2][0:2][3:0] kern_t;

  localparam kern_t K_PASS = {4'h0, 4'h0, 4'h0,
                              4'h0, 4'h1, 4'h0,
                              4'h0, 4'h0, 4'h0};
  localparam kern_t K_SOBX = {4'hF, 4'h0, 4'h1,
                              4'hE, 4'h0, 4'h2,
                              4'hF, 4'h0, 4'h1};
  localparam kern_t K_SOBY = {4'hF, 4'hE, 4'hF,
                              4'h0, 4'h0, 4'h0,
                              4'h1, 4'h2, 4'h1};
  localparam kern_t K_LAP  = {4'h0, 4'hF, 4'h0,
                              4'hF, 4'h4, 4'hF,
                              4'h0, 4'hF, 4'h0};

  function automatic int ACC_W(input int data_w);
    return data_w + 4;
  endfunction

  function automatic kern_t kernel_of(input logic [1:0] mode);
    case (mode)
      MODE_SOBX: return K_SOBX;
      MODE_SOBY: return K_SOBY;
      MODE_LAP:  return K_LAP;
      default:   return K_PASS;
    endcase
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_ram.sv
// Simple dual-port line buffer with a registered (1-cycle) read port.
// A read and write to the same address in one cycle returns the old word.
module line_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 640
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution (pass / Sobel-X / Sobel-Y / Laplacian) on a grey
// pixel stream; define CONV_THRESH_EN to add a binary threshold on the output.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int BORDER  = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
`ifdef CONV_THRESH_EN
  input  logic [DATA_W-1:0] iTHRESH,
`endif
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oSOF
);

  localparam int AW = ACC_W(DATA_W);
  localparam int XW = $clog2(LINE_W);
  localparam int YW = $clog2(FRAME_H);

  logic [XW-1:0]     r_x, w_x, r_x1;
  logic [YW-1:0]     r_y, w_y, r_y1;
  logic [1:0]        r_mode, w_mode, r_mode1, r_mode2;
  logic              w_sof;
  logic              r_v1, r_v2;
  logic [DATA_W-1:0] r_p1;
  logic              w_mask1, r_mask2, r_sof2;
  logic [DATA_W-1:0] w_ram1_q, w_ram2_q;
  logic [DATA_W-1:0] r_win [3][3];
  kern_t             w_k;
  logic signed [AW-1:0] w_sum;
  logic [AW-1:0]     w_mag;
  logic [DATA_W-1:0] w_res, w_out;

  assign w_sof  = iDVAL & iSOF;
  assign w_x    = w_sof ? '0 : r_x;
  assign w_y    = w_sof ? '0 : r_y;
  assign w_mode = w_sof ? iMODE : r_mode;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= MODE_PASS;
    end else if (iDVAL) begin
      r_mode <= w_mode;
      if (w_x == XW'(LINE_W - 1)) begin
        r_x <= '0;
        r_y <= (w_y == YW'(FRAME_H - 1)) ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

  // Row-1 buffer is written with the incoming pixel; row-2 buffer is fed one
  // cycle later from row-1's read-before-write output at the same column.
  line_ram #(.DATA_W(DATA_W), .DEPTH(LINE_W)) u_ram1 (
    .i_clk   (iCLK),
    .i_we    (iDVAL),
    .i_waddr (w_x),
    .i_wdata (iDATA),
    .i_re    (iDVAL),
    .i_raddr (w_x),
    .o_rdata (w_ram1_q)
  );

  line_ram #(.DATA_W(DATA_W), .DEPTH(LINE_W)) u_ram2 (
    .i_clk   (iCLK),
    .i_we    (r_v1),
    .i_waddr (r_x1),
    .i_wdata (w_ram1_q),
    .i_re    (iDVAL),
    .i_raddr (w_x),
    .o_rdata (w_ram2_q)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_v1    <= 1'b0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_p1    <= '0;
      r_mode1 <= MODE_PASS;
    end else begin
      r_v1 <= iDVAL;
      if (iDVAL) begin
        r_x1    <= w_x;
        r_y1    <= w_y;
        r_p1    <= iDATA;
        r_mode1 <= w_mode;
      end
    end
  end

  // Centre of the window is (x1-1, y1-1); mask in input coordinates.
  assign w_mask1 = (int'(r_x1) < BORDER + 1) || (int'(r_y1) < BORDER + 1) ||
                   (int'(r_x1) > LINE_W - BORDER) || (int'(r_y1) > FRAME_H - BORDER);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_v2    <= 1'b0;
      r_mask2 <= 1'b0;
      r_sof2  <= 1'b0;
      r_mode2 <= MODE_PASS;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
    end else begin
      r_v2 <= r_v1 && (r_x1 != '0) && (r_y1 != '0);
      if (r_v1) begin
        r_mask2 <= w_mask1;
        r_sof2  <= (r_x1 == XW'(1)) && (r_y1 == YW'(1));
        r_mode2 <= r_mode1;
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_ram2_q;
        r_win[1][2] <= w_ram1_q;
        r_win[2][2] <= r_p1;
      end
    end
  end

  always_comb begin
    w_k   = kernel_of(r_mode2);
    w_sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_sum = w_sum + $signed({{(AW-DATA_W){1'b0}}, r_win[r][c]}) *
                        $signed({{(AW-4){w_k[r][c][3]}}, w_k[r][c]});
  end

  assign w_mag = w_sum[AW-1] ? -w_sum : w_sum;
  assign w_res = (|w_mag[AW-1:DATA_W]) ? '1 : w_mag[DATA_W-1:0];

`ifdef CONV_THRESH_EN
  logic [DATA_W-1:0] r_thr, w_thr, r_thr1, r_thr2;
  logic [DATA_W-1:0] w_masked;

  assign w_thr = w_sof ? iTHRESH : r_thr;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_thr  <= '0;
      r_thr1 <= '0;
      r_thr2 <= '0;
    end else begin
      if (iDVAL) begin
        r_thr  <= w_thr;
        r_thr1 <= w_thr;
      end
      if (r_v1) r_thr2 <= r_thr1;
    end
  end

  assign w_masked = r_mask2 ? '0 : w_res;
  assign w_out    = (w_masked >= r_thr2) ? '1 : '0;
`else
  assign w_out = r_mask2 ? '0 : w_res;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDATA <= '0;
      oDVAL <= 1'b0;
      oSOF  <= 1'b0;
    end else begin
      oDVAL <= r_v2;
      oSOF  <= r_v2 & r_sof2;
      oDATA <= r_v2 ? w_out : '0;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream on an 8x6 frame: table of frames
// checked against a convolution model via a scoreboard, plus corner sequences.
module tb_conv3x3_stream;

  localparam int DW = 12;
  localparam int LW = 8;
  localparam int FH = 6;
  localparam int BD = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          idval = 1'b0;
  logic          isof = 1'b0;
  logic [1:0]    imode = 2'b00;
  logic [DW-1:0] odata;
  logic          odval;
  logic          osof;

  conv3x3_stream #(.DATA_W(DW), .LINE_W(LW), .FRAME_H(FH), .BORDER(BD)) dut (
    .iCLK  (clk),
    .iRST  (rst_n),
    .iDATA (idata),
    .iDVAL (idval),
    .iSOF  (isof),
    .iMODE (imode),
    .oDATA (odata),
    .oDVAL (odval),
    .oSOF  (osof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    int            cyc;
  } exp_t;

  typedef struct {
    int         pat;
    logic [1:0] mode;
    int         gap;
    int         exp_nz;
    int         exp_sum;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[7];
  int   img[FH][LW];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_out, nz_out, sum_out;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!odval && osof) begin
        n_tests++;
        n_fail++;
        $display("FAIL osof_qual: oSOF=1 with oDVAL=0 at cycle %0d", cyc);
      end
      if (odval) begin
        n_out++;
        sum_out += int'(odata);
        if (odata != '0) nz_out++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got data %0d at cycle %0d, expected no output", odata, cyc);
        end else begin
          mon_e = q.pop_front();
          check("data", int'(odata), int'(mon_e.data));
          check("sof", int'(osof), int'(mon_e.sof));
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  function automatic int golden(int cx, int cy, logic [1:0] m);
    int v;
    if (cx < BD || cy < BD || cx > LW - 1 - BD || cy > FH - 1 - BD) return 0;
    case (m)
      2'b00: v = img[cy][cx];
      2'b01: v = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
      2'b10: v = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
               - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
      default: v = 4*img[cy][cx] - img[cy-1][cx] - img[cy+1][cx]
                 - img[cy][cx-1] - img[cy][cx+1];
    endcase
    if (v < 0) v = -v;
    if (v > 4095) v = 4095;
    return v;
  endfunction

  task automatic fill(input int pat);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < LW; x++)
        case (pat)
          0: img[y][x] = 100;
          1: img[y][x] = (x < 4) ? 0 : 100;
          2: img[y][x] = (x < 4) ? 0 : 4095;
          3: img[y][x] = x + 8*y;
          default: img[y][x] = (x == 3 && y == 2) ? 1000 : 0;
        endcase
  endtask

  task automatic drive_pix(input int d, input logic sof, input logic [1:0] mode);
    @(negedge clk);
    idata = DW'(d);
    idval = 1'b1;
    isof  = sof;
    imode = mode;
  endtask

  // Idle cycles carry junk data, SOF and mode, all of which must be ignored.
  task automatic drive_idle();
    @(negedge clk);
    idval = 1'b0;
    idata = DW'($urandom);
    isof  = 1'($urandom);
    imode = 2'($urandom);
  endtask

  task automatic drive_frame(input int pat, input logic [1:0] mode,
                             input logic [1:0] mid_mode, input int gap, input int npix);
    exp_t ce;
    fill(pat);
    n_out = 0;
    nz_out = 0;
    sum_out = 0;
    for (int i = 0; i < npix; i++) begin
      int x, y;
      x = i % LW;
      y = i / LW;
      drive_pix(img[y][x], i == 0, (i == 0) ? mode : mid_mode);
      if (x >= 1 && y >= 1) begin
        ce.data = DW'(golden(x - 1, y - 1, mode));
        ce.sof  = (x == 1 && y == 1);
        ce.cyc  = cyc + 3;
        q.push_back(ce);
      end
      for (int g = 0; g < gap; g++) drive_idle();
    end
    drive_idle();
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic frame_check(input string name, input int exp_nz, input int exp_sum);
    check({name, "_count"}, n_out, (LW - 1) * (FH - 1));
    check({name, "_nonzero"}, nz_out, exp_nz);
    check({name, "_sum"}, sum_out, exp_sum);
  endtask

  initial begin
    tbl[0] = '{0, 2'b01, 0, 0, 0};
    tbl[1] = '{1, 2'b01, 0, 8, 3200};
    tbl[2] = '{2, 2'b01, 0, 8, 32760};
    tbl[3] = '{2, 2'b10, 0, 0, 0};
    tbl[4] = '{3, 2'b00, 1, 24, 564};
    tbl[5] = '{3, 2'b01, 2, 24, 192};
    tbl[6] = '{4, 2'b11, 0, 5, 8000};

    repeat (3) @(negedge clk);
    check("reset_odata", int'(odata), 0);
    check("reset_odval", int'(odval), 0);
    check("reset_osof", int'(osof), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive_frame(tbl[i].pat, tbl[i].mode, ~tbl[i].mode, tbl[i].gap, LW * FH);
      drain();
      frame_check($sformatf("vec%0d", i), tbl[i].exp_nz, tbl[i].exp_sum);
    end

    // Mode switched to Sobel-Y mid-frame must not affect the current frame.
    drive_frame(1, 2'b01, 2'b10, 0, LW * FH);
    drain();
    frame_check("modechg_cur", 8, 3200);
    drive_frame(3, 2'b10, 2'b01, 0, LW * FH);
    drain();
    frame_check("modechg_next", 24, 1536);

    // Asynchronous reset while outputs are streaming.
    drive_frame(3, 2'b00, 2'b00, 0, 21);
    #2;
    mon_en = 1'b0;
    check("prerst_odval", int'(odval), 1);
    check("prerst_odata", int'(odata), 9);
    rst_n = 1'b0;
    #1;
    check("asyncrst_odval", int'(odval), 0);
    check("asyncrst_odata", int'(odata), 0);
    check("asyncrst_osof", int'(osof), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    drive_frame(4, 2'b11, 2'b00, 0, LW * FH);
    drain();
    frame_check("postrst", 5, 8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
